// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM states.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MDU_OP_NONE  = 3'd0,
    MDU_OP_MULT  = 3'd1,
    MDU_OP_MULTU = 3'd2,
    MDU_OP_DIV   = 3'd3,
    MDU_OP_DIVU  = 3'd4,
    MDU_OP_MTHI  = 3'd5,
    MDU_OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// E-stage <-> multiply/divide unit connection.
// Handshake: the E stage pulses start for one cycle when busy is low. busy marks a
// running operation. done pulses once when new HI/LO becomes visible.
interface md_unit_if #(parameter int WIDTH = 32);
  import md_unit_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  md_state_e        state;

  modport master (output start, op, src_a, src_b, cancel,
                  input  busy, done, hi, lo, state);
  modport slave  (input  start, op, src_a, src_b, cancel,
                  output busy, done, hi, lo, state);
endinterface

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu from latched operands.
module md_arith
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0]      prod_s;
  logic [2*WIDTH-1:0]      prod_u;
  logic                    div_zero;
  logic                    div_ovf;
  logic [WIDTH-1:0]        b_sdiv;
  logic [WIDTH-1:0]        b_udiv;
  logic signed [WIDTH-1:0] q_s;
  logic signed [WIDTH-1:0] r_s;
  logic [WIDTH-1:0]        q_u;
  logic [WIDTH-1:0]        r_u;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  assign div_zero = (b_i == '0);
  assign div_ovf  = (a_i == MIN_NEG) && (b_i == '1);

  // Divisors are steered away from zero and the overflow pair so the dividers never trap.
  assign b_sdiv = (div_zero || div_ovf) ? ONE : b_i;
  assign b_udiv = div_zero ? ONE : b_i;

  assign q_s = $signed(a_i) / $signed(b_sdiv);
  assign r_s = $signed(a_i) % $signed(b_sdiv);
  assign q_u = a_i / b_udiv;
  assign r_u = a_i % b_udiv;

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    case (op_i)
      MDU_OP_MULT: begin
        hi_o = prod_s[2*WIDTH-1:WIDTH];
        lo_o = prod_s[WIDTH-1:0];
      end
      MDU_OP_MULTU: begin
        hi_o = prod_u[2*WIDTH-1:WIDTH];
        lo_o = prod_u[WIDTH-1:0];
      end
      MDU_OP_DIV: begin
        if (div_zero) begin
          hi_o = a_i;
          lo_o = '1;
        end else if (div_ovf) begin
          hi_o = '0;
          lo_o = MIN_NEG;
        end else begin
          hi_o = r_s;
          lo_o = q_s;
        end
      end
      MDU_OP_DIVU: begin
        if (div_zero) begin
          hi_o = a_i;
          lo_o = '1;
        end else begin
          hi_o = r_u;
          lo_o = q_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: IDLE/RUN FSM, latency counter and the HI/LO architectural registers.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  md_op_e           op_in;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign op_in = md_op_e'(md.op);

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_o (res_hi),
    .lo_o (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MDU_OP_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // cancel alongside start suppresses the issue entirely
        if (md.start && !md.cancel) begin
          case (op_in)
            MDU_OP_MULT, MDU_OP_MULTU: begin
              a_d     = md.src_a;
              b_d     = md.src_b;
              op_d    = op_in;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
              a_d     = md.src_a;
              b_d     = md.src_b;
              op_d    = op_in;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_RUN;
            end
            MDU_OP_MTHI: hi_d = md.src_a;
            MDU_OP_MTLO: lo_d = md.src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // cancel takes priority over completion, so an aborted op never writes HI/LO
        if (md.cancel) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign md.busy  = (state_q == ST_RUN);
  assign md.done  = done_q;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.state = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a stimulus thread queues expected HI/LO, a monitor checks on done.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(W)) m0 ();
  md_unit_if #(.WIDTH(W)) m1 ();

  md_unit #(.WIDTH(W)) dut0 (
    .clk   (clk),
    .reset (reset),
    .md    (m0)
  );

  md_unit #(.WIDTH(W), .MULT_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .md    (m1)
  );

  logic [2*W-1:0] exp_q0[$];
  logic [2*W-1:0] exp_q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every done pulse consumes one expected {hi,lo}
  always @(negedge clk) begin
    if (m0.done) begin
      if (exp_q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done0_unexpected: got done=1 hi=%h lo=%h expected no done", m0.hi, m0.lo);
      end else begin
        check("result0", {m0.hi, m0.lo}, exp_q0.pop_front());
      end
    end
    if (m1.done) begin
      if (exp_q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done1_unexpected: got done=1 hi=%h lo=%h expected no done", m1.hi, m1.lo);
      end else begin
        check("result1", {m1.hi, m1.lo}, exp_q1.pop_front());
      end
    end
  end

  task automatic pulse(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    @(negedge clk);
    m0.start  = 1'b1;
    m0.op     = op;
    m0.src_a  = a;
    m0.src_b  = b;
    m0.cancel = c;
    @(negedge clk);
    m0.start  = 1'b0;
    m0.op     = MDU_OP_NONE;
    m0.cancel = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (m0.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    m0.start  = 1'b0; m0.op = MDU_OP_NONE; m0.src_a = '0; m0.src_b = '0; m0.cancel = 1'b0;
    m1.start  = 1'b0; m1.op = MDU_OP_NONE; m1.src_a = '0; m1.src_b = '0; m1.cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_hi", m0.hi, 0);
    check("rst_lo", m0.lo, 0);
    check("rst_busy", m0.busy, 0);
    check("rst_done", m0.done, 0);
    check("rst_state", m0.state, ST_IDLE);

    exp_q0.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
    pulse(MDU_OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0);
    count_busy(n);
    check("mult_busy", n, 5);

    exp_q0.push_back({32'h00000001, 32'hFFFFFFFE});
    pulse(MDU_OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    count_busy(n);
    check("multu_busy", n, 5);

    exp_q0.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    pulse(MDU_OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    count_busy(n);
    check("div_busy", n, 10);

    exp_q0.push_back({32'h00000007, 32'hFFFFFFFF});
    pulse(MDU_OP_DIVU, 32'd7, 32'd0, 1'b0);
    count_busy(n);
    check("divu0_busy", n, 10);

    exp_q0.push_back({32'h00000000, 32'h80000000});
    pulse(MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    count_busy(n);
    check("div_ovf_busy", n, 10);

    pulse(MDU_OP_MTHI, 32'h1234, 32'd0, 1'b0);
    check("mthi_hi", m0.hi, 32'h1234);
    check("mthi_busy", m0.busy, 0);
    pulse(MDU_OP_MTLO, 32'h5678, 32'd0, 1'b0);
    check("mtlo_lo", m0.lo, 32'h5678);
    check("mtlo_hi_kept", m0.hi, 32'h1234);
    check("mtlo_busy", m0.busy, 0);

    // second start mid-run must be dropped, not queued
    exp_q0.push_back({32'h00000000, 32'h0000000C});
    pulse(MDU_OP_MULT, 32'd3, 32'd4, 1'b0);
    check("hi_stable_run", m0.hi, 32'h1234);
    check("run_state", m0.state, ST_RUN);
    pulse(MDU_OP_DIV, 32'd100, 32'd7, 1'b0);
    count_busy(n);
    check("ignored_start_busy", n, 3);
    repeat (12) @(negedge clk);
    check("no_queued_op", m0.busy, 0);

    pulse(MDU_OP_MTHI, 32'hAAAA, 32'd0, 1'b0);
    pulse(MDU_OP_MTLO, 32'h5555, 32'd0, 1'b0);

    pulse(MDU_OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    m0.cancel = 1'b1;
    @(negedge clk);
    m0.cancel = 1'b0;
    check("cancel3_busy", m0.busy, 0);
    check("cancel3_hi", m0.hi, 32'hAAAA);
    check("cancel3_lo", m0.lo, 32'h5555);
    repeat (12) @(negedge clk);
    check("cancel3_later_hi", m0.hi, 32'hAAAA);

    pulse(MDU_OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    check("cancel_last_busy_pre", m0.busy, 1);
    m0.cancel = 1'b1;
    @(negedge clk);
    m0.cancel = 1'b0;
    check("cancel_last_busy", m0.busy, 0);
    check("cancel_last_hi", m0.hi, 32'hAAAA);
    check("cancel_last_lo", m0.lo, 32'h5555);
    repeat (3) @(negedge clk);

    pulse(MDU_OP_MULT, 32'd5, 32'd5, 1'b1);
    check("start_cancel_busy", m0.busy, 0);
    pulse(MDU_OP_MTHI, 32'hDEAD, 32'd0, 1'b1);
    check("mthi_cancel_hi", m0.hi, 32'hAAAA);
    pulse(MDU_OP_NONE, 32'hBEEF, 32'hBEEF, 1'b0);
    check("none_busy", m0.busy, 0);
    check("none_hilo", {m0.hi, m0.lo}, {32'hAAAA, 32'h5555});

    pulse(MDU_OP_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_hi", m0.hi, 0);
    check("rst_mid_lo", m0.lo, 0);
    check("rst_mid_busy", m0.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_mid_after_busy", m0.busy, 0);

    exp_q0.push_back({32'h00000000, 32'h0000002A});
    pulse(MDU_OP_MULT, 32'd6, 32'd7, 1'b0);
    count_busy(n);
    check("post_rst_mult_busy", n, 5);

    // one-cycle multiply latency on the second instance
    exp_q1.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
    @(negedge clk);
    m1.start = 1'b1; m1.op = MDU_OP_MULT; m1.src_a = 32'hFFFFFFFF; m1.src_b = 32'd2;
    @(negedge clk);
    m1.start = 1'b0; m1.op = MDU_OP_NONE;
    n = 0;
    while (m1.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("mult1_busy", n, 1);

    repeat (3) @(negedge clk);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
